// File: rtl/accumulator_bank.sv
// accumulator_bank: four 8-bit accumulator registers for the accumulator-style datapath.
//
// One register number addresses both the write side (the ALU result bus) and the read side
// (the ALU operand / memory-address path). A write lands on the rising clock edge. The read
// port is purely combinational.
//
// Ports:
//   clock           rising-edge clock for all state
//   reset           synchronous, active-high; clears every register, overrides regWrite
//   regWrite        write enable, sampled on the rising edge
//   RegisterNumber  selects the register for both write and read (modulo NUM_REGS)
//   writeData       value stored verbatim into the selected register
//   readData        current contents of the selected register (no write-through bypass)
module accumulator_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic [SEL_WIDTH-1:0]  RegisterNumber,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_en;

  // One-hot write decode; only SEL_WIDTH bits exist, so addressing is inherently modulo.
  always_comb begin
    wr_en = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_en[i] = regWrite && (RegisterNumber == SEL_WIDTH'(i));
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else if (wr_en[i]) begin
        regs_q[i] <= writeData;
      end
    end
  end

  // The read deliberately ignores writeData: the old value stays visible until the edge.
  assign readData = regs_q[RegisterNumber];

endmodule

// File: tb/tb_accumulator_bank.sv
module tb_accumulator_bank;

  logic       clock = 1'b0;
  logic       reset;
  logic       regWrite;
  logic [1:0] RegisterNumber;
  logic [7:0] writeData;
  logic [7:0] readData;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: an array of four bytes plus a flag telling whether a reset has been seen.
  logic [7:0] model [4];
  bit         model_valid = 1'b0;

  accumulator_bank dut (
    .clock          (clock),
    .reset          (reset),
    .regWrite       (regWrite),
    .RegisterNumber (RegisterNumber),
    .writeData      (writeData),
    .readData       (readData)
  );

  always #5 clock = ~clock;

  // Inputs are stable at the edge (driven 2 time units after it), so the model sees the
  // same values the DUT samples.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) model[i] = 8'h00;
      model_valid = 1'b1;
    end else if (regWrite && model_valid) begin
      model[RegisterNumber] = writeData;
    end
  end

  // Continuous comparison mid-cycle, once contents are defined.
  always @(negedge clock) begin
    if (model_valid) begin
      vectors++;
      if (readData !== model[RegisterNumber]) begin
        miscompares++;
        $display("FAIL cycle_read sel=%0d got=%h expected=%h", RegisterNumber, readData,
                 model[RegisterNumber]);
      end
    end
  end

  // Drive a new input set just after the next rising edge, then let it settle.
  task automatic apply(input logic r, input logic w, input logic [1:0] s, input logic [7:0] d);
    @(posedge clock);
    #2;
    reset = r;
    regWrite = w;
    RegisterNumber = s;
    writeData = d;
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] expected);
    vectors++;
    if (readData !== expected) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, readData, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    regWrite = 1'b0;
    RegisterNumber = 2'd0;
    writeData = 8'h00;

    // Reset, then sweep every register.
    apply(1'b1, 1'b0, 2'd0, 8'h00);
    for (int s = 0; s < 4; s++) begin
      apply(1'b0, 1'b0, 2'(s), 8'hFF);
      check($sformatf("reset_r%0d", s), 8'h00);
    end

    // Basic write to R1; readData must not bypass before the edge.
    apply(1'b0, 1'b1, 2'd1, 8'h03);
    check("pre_edge_r1", 8'h00);
    apply(1'b0, 1'b0, 2'd1, 8'h00);
    check("write_r1", 8'h03);
    apply(1'b0, 1'b0, 2'd0, 8'h00);
    check("untouched_r0", 8'h00);
    apply(1'b0, 1'b0, 2'd2, 8'h00);
    check("untouched_r2", 8'h00);
    apply(1'b0, 1'b0, 2'd3, 8'h00);
    check("untouched_r3", 8'h00);

    // Second register, then hold with junk on writeData.
    apply(1'b0, 1'b1, 2'd0, 8'h05);
    apply(1'b0, 1'b0, 2'd0, 8'hFF);
    check("write_r0", 8'h05);
    apply(1'b0, 1'b0, 2'd1, 8'hFF);
    check("hold_r1", 8'h03);
    apply(1'b0, 1'b0, 2'd0, 8'hFF);
    check("hold_r0", 8'h05);

    // Back-to-back overwrite of R3 and full-range value into R2.
    apply(1'b0, 1'b1, 2'd3, 8'hAA);
    apply(1'b0, 1'b1, 2'd3, 8'h55);
    check("overwrite_first", 8'hAA);
    apply(1'b0, 1'b0, 2'd3, 8'h00);
    check("overwrite_second", 8'h55);
    apply(1'b0, 1'b1, 2'd2, 8'hFF);
    apply(1'b0, 1'b0, 2'd2, 8'h00);
    check("full_range_r2", 8'hFF);

    // Reset wins over a simultaneous write; the write path works on the very next edge.
    apply(1'b1, 1'b1, 2'd0, 8'h77);
    apply(1'b0, 1'b1, 2'd1, 8'h77);
    check("reset_priority_r1", 8'h00);
    apply(1'b0, 1'b0, 2'd0, 8'h00);
    check("reset_priority_r0", 8'h00);
    apply(1'b0, 1'b0, 2'd1, 8'h00);
    check("post_reset_write_r1", 8'h77);
    apply(1'b0, 1'b0, 2'd2, 8'h00);
    check("post_reset_r2", 8'h00);
    apply(1'b0, 1'b0, 2'd3, 8'h00);
    check("post_reset_r3", 8'h00);

    // No bypass: old R2 stays visible until the capturing edge.
    apply(1'b0, 1'b1, 2'd2, 8'h34);
    apply(1'b0, 1'b1, 2'd2, 8'h12);
    check("no_bypass_before", 8'h34);
    apply(1'b0, 1'b0, 2'd2, 8'h00);
    check("no_bypass_after", 8'h12);

    // Randomised traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      apply(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), 8'($urandom));
    end

    @(posedge clock);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
